// File: rtl/branch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : branch_sequencer
//  Purpose  : Fetch-redirect controller for a 5-stage pipeline with one
//             branch delay slot.
//             - Jumps (J/JAL/JR) are issued from ID in the same cycle.
//             - Conditional branches are resolved in EX from the {Z,N} flags.
//             - A taken branch that meets a hazard stall is parked as a
//               pending redirect, so the delay slot is never lost.
//  Option   : `define BRANCH_STATS_EN builds saturating branch/taken counters.
//             Without it, the stat outputs are tied to zero and no counter
//             flops exist.
//  Ports    : clk, reset (async, active-high)
//             stall_in                   - hazard stall, freezes PC and IF/ID
//             id_b_instr/id_uncond/id_ta_instr - ID-stage branch/jump info
//             ex_b_instr/ex_opcode/ex_flag/ex_ta - EX-stage branch info
//             pc_sel, pc_ld, ifid_ld, flush_ifid - fetch controls
//             held_ta, busy, ds_err      - status
//             stat_branches, stat_taken  - optional statistics
//  Revision : 1.0  initial release
// ============================================================================
module branch_sequencer #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_in,
   input  logic              id_b_instr,
   input  logic              id_uncond,
   input  logic              id_ta_instr,
   input  logic              ex_b_instr,
   input  logic [5:0]        ex_opcode,
   input  logic [1:0]        ex_flag,
   input  logic [ADDR_W-1:0] ex_ta,
   output logic [2:0]        pc_sel,
   output logic              pc_ld,
   output logic              ifid_ld,
   output logic              flush_ifid,
   output logic [ADDR_W-1:0] held_ta,
   output logic              busy,
   output logic              ds_err,
   output logic [CNT_W-1:0]  stat_branches,
   output logic [CNT_W-1:0]  stat_taken
);

   localparam logic [2:0] c_SEL_NPC   = 3'b000;
   localparam logic [2:0] c_SEL_EX_TA = 3'b001;
   localparam logic [2:0] c_SEL_ID_TA = 3'b010;
   localparam logic [2:0] c_SEL_RS    = 3'b011;
   localparam logic [2:0] c_SEL_HELD  = 3'b100;

   localparam logic [5:0] c_OP_BR1 = 6'b000001;
   localparam logic [5:0] c_OP_BR7 = 6'b000111;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_EX = 2'd1,
      PENDING = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   held_ta_q, held_ta_d;
   logic                ds_err_q, ds_err_d;
   logic                w_cond_ok;
   logic                w_taken;

   // Condition evaluation: opcode 000001 falls through only on N-set/Z-clear,
   // opcode 000111 falls through whenever Z is set; anything else flagged as
   // a branch is taken unconditionally.
   always_comb begin
      w_cond_ok = 1'b1;
      case (ex_opcode)
         c_OP_BR1: w_cond_ok = (ex_flag != 2'b01);
         c_OP_BR7: w_cond_ok = ~ex_flag[1];
         default:  w_cond_ok = 1'b1;
      endcase
      w_taken = ex_b_instr & w_cond_ok;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         held_ta_q <= '0;
         ds_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         held_ta_q <= held_ta_d;
         ds_err_q  <= ds_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      held_ta_d  = held_ta_q;
      ds_err_d   = ds_err_q;
      pc_sel     = c_SEL_NPC;
      pc_ld      = ~stall_in;
      ifid_ld    = ~stall_in;
      flush_ifid = 1'b0;

      case (state_q)
         IDLE: begin
            // A stalled jump stays in ID and is issued once the stall clears.
            if (!stall_in && id_b_instr) begin
               if (id_uncond) begin
                  // Delay slot is already in IF, so nothing is squashed.
                  pc_sel = id_ta_instr ? c_SEL_ID_TA : c_SEL_RS;
                  pc_ld  = 1'b1;
               end else begin
                  state_d = WAIT_EX;
               end
            end
         end

         WAIT_EX: begin
            // The delay slot sits in ID now; a branch there is illegal.
            if (id_b_instr) begin
               ds_err_d = 1'b1;
            end
            if (w_taken && !stall_in) begin
               pc_sel     = c_SEL_EX_TA;
               pc_ld      = 1'b1;
               flush_ifid = 1'b1;
               state_d    = IDLE;
            end else if (w_taken) begin
               // ex_ta is only valid this cycle, so capture it for later.
               held_ta_d = ex_ta;
               state_d   = PENDING;
            end else begin
               state_d = IDLE;
            end
         end

         PENDING: begin
            if (!stall_in) begin
               pc_sel     = c_SEL_HELD;
               pc_ld      = 1'b1;
               flush_ifid = 1'b1;
               state_d    = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Fetch is fully frozen while reset is held.
      if (reset) begin
         pc_sel     = c_SEL_NPC;
         pc_ld      = 1'b0;
         ifid_ld    = 1'b0;
         flush_ifid = 1'b0;
      end
   end

   assign held_ta = held_ta_q;
   assign ds_err  = ds_err_q;
   assign busy    = (state_q != IDLE);

`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] stat_br_q;
   logic [CNT_W-1:0] stat_tk_q;
   logic             w_resolve;

   // Every cycle spent in WAIT_EX resolves exactly one branch.
   assign w_resolve = (state_q == WAIT_EX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_br_q <= '0;
         stat_tk_q <= '0;
      end else if (w_resolve) begin
         if (stat_br_q != {CNT_W{1'b1}}) begin
            stat_br_q <= stat_br_q + 1'b1;
         end
         if (w_taken && (stat_tk_q != {CNT_W{1'b1}})) begin
            stat_tk_q <= stat_tk_q + 1'b1;
         end
      end
   end

   assign stat_branches = stat_br_q;
   assign stat_taken    = stat_tk_q;
`else
   assign stat_branches = '0;
   assign stat_taken    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_sequencer
//  Purpose  : Self-checking bench for branch_sequencer: directed scenarios
//             followed by random traffic, compared cycle by cycle against a
//             behavioural model of the redirect rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_sequencer;

   localparam int ADDR_W = 32;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              stall_in;
   logic              id_b_instr;
   logic              id_uncond;
   logic              id_ta_instr;
   logic              ex_b_instr;
   logic [5:0]        ex_opcode;
   logic [1:0]        ex_flag;
   logic [ADDR_W-1:0] ex_ta;
   logic [2:0]        pc_sel;
   logic              pc_ld;
   logic              ifid_ld;
   logic              flush_ifid;
   logic [ADDR_W-1:0] held_ta;
   logic              busy;
   logic              ds_err;
   logic [CNT_W-1:0]  stat_branches;
   logic [CNT_W-1:0]  stat_taken;

   always #5 clk = ~clk;

   branch_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall_in     (stall_in),
      .id_b_instr   (id_b_instr),
      .id_uncond    (id_uncond),
      .id_ta_instr  (id_ta_instr),
      .ex_b_instr   (ex_b_instr),
      .ex_opcode    (ex_opcode),
      .ex_flag      (ex_flag),
      .ex_ta        (ex_ta),
      .pc_sel       (pc_sel),
      .pc_ld        (pc_ld),
      .ifid_ld      (ifid_ld),
      .flush_ifid   (flush_ifid),
      .held_ta      (held_ta),
      .busy         (busy),
      .ds_err       (ds_err),
      .stat_branches(stat_branches),
      .stat_taken   (stat_taken)
   );

   int total = 0;
   int bad   = 0;

   // Model: a conditional branch waiting in EX, a parked redirect, and
   // the sticky/statistics bookkeeping.
   bit                m_br_in_ex;
   bit                m_hold_v;
   logic [ADDR_W-1:0] m_hold_ta;
   bit                m_ds;
   int                m_nb;
   int                m_nt;

   function automatic bit rule_taken(input logic exb, input logic [5:0] op,
                                     input logic [1:0] fl);
      bit t;
      if (op == 6'd1)      t = (fl != 2'b01);
      else if (op == 6'd7) t = (fl < 2'd2);
      else                 t = 1'b1;
      return exb && t;
   endfunction

   function automatic logic [63:0] sat_cnt(input int n);
      int lim;
      lim = (1 << CNT_W) - 1;
      return (n > lim) ? 64'(lim) : 64'(n);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit r, input bit s, input bit idb, input bit unc,
                       input bit tai, input bit exb, input logic [5:0] op,
                       input logic [1:0] fl, input logic [ADDR_W-1:0] ta);
      logic [2:0]        e_sel;
      bit                e_fl;
      bit                e_ld;
      bit                tk;
      bit                n_br, n_hv, n_ds;
      logic [ADDR_W-1:0] n_hta;
      int                n_nb, n_nt;
      logic [63:0]       e_sb, e_st;

      @(negedge clk);
      reset = r; stall_in = s; id_b_instr = idb; id_uncond = unc;
      id_ta_instr = tai; ex_b_instr = exb; ex_opcode = op; ex_flag = fl;
      ex_ta = ta;
      #1;
      if (r) begin
         m_br_in_ex = 0; m_hold_v = 0; m_hold_ta = '0; m_ds = 0;
         m_nb = 0; m_nt = 0;
      end
      e_sel = 3'd0; e_fl = 0;
      e_ld  = !r && !s;
      n_br = m_br_in_ex; n_hv = m_hold_v; n_hta = m_hold_ta; n_ds = m_ds;
      n_nb = m_nb; n_nt = m_nt;
      if (!r) begin
         if (m_hold_v) begin
            if (!s) begin e_sel = 3'd4; e_fl = 1; n_hv = 0; end
         end else if (m_br_in_ex) begin
            tk   = rule_taken(exb, op, fl);
            n_br = 0;
            n_nb = m_nb + 1;
            if (tk) n_nt = m_nt + 1;
            if (idb) n_ds = 1;
            if (tk && !s) begin
               e_sel = 3'd1; e_fl = 1;
            end else if (tk) begin
               n_hv = 1; n_hta = ta;
            end
         end else if (!s && idb) begin
            if (unc) e_sel = tai ? 3'd2 : 3'd3;
            else     n_br = 1;
         end
      end
`ifdef BRANCH_STATS_EN
      e_sb = sat_cnt(m_nb);
      e_st = sat_cnt(m_nt);
`else
      e_sb = 64'd0;
      e_st = 64'd0;
`endif
      chk("pc_sel",        64'(pc_sel),        64'(e_sel));
      chk("pc_ld",         64'(pc_ld),         64'(e_ld));
      chk("ifid_ld",       64'(ifid_ld),       64'(e_ld));
      chk("flush_ifid",    64'(flush_ifid),    64'(e_fl));
      chk("busy",          64'(busy),          64'(m_br_in_ex | m_hold_v));
      chk("held_ta",       64'(held_ta),       64'(m_hold_ta));
      chk("ds_err",        64'(ds_err),        64'(m_ds));
      chk("stat_branches", 64'(stat_branches), e_sb);
      chk("stat_taken",    64'(stat_taken),    e_st);
      @(posedge clk);
      m_br_in_ex = n_br; m_hold_v = n_hv; m_hold_ta = n_hta; m_ds = n_ds;
      m_nb = n_nb; m_nt = n_nt;
   endtask

   // One conditional branch: ID cycle then EX cycle (no stall).
   task automatic cond_branch(input logic [5:0] op, input logic [1:0] fl,
                              input logic [ADDR_W-1:0] ta);
      step(0, 0, 1, 0, 0, 0, 6'd0, 2'd0, '0);
      step(0, 0, 0, 0, 0, 1, op, fl, ta);
   endtask

   initial begin
      reset = 1; stall_in = 0; id_b_instr = 0; id_uncond = 0; id_ta_instr = 0;
      ex_b_instr = 0; ex_opcode = '0; ex_flag = '0; ex_ta = '0;
      m_br_in_ex = 0; m_hold_v = 0; m_hold_ta = '0; m_ds = 0; m_nb = 0; m_nt = 0;

      // Reset state
      step(1, 0, 0, 0, 0, 0, 6'd0, 2'd0, '0);
      step(1, 1, 1, 1, 1, 1, 6'd1, 2'd0, 32'hDEAD);
      step(0, 0, 0, 0, 0, 0, 6'd0, 2'd0, '0);

      // Jumps to ID_TA and rs, plus a jump held by a stall
      step(0, 0, 1, 1, 1, 0, 6'd0, 2'd0, '0);
      step(0, 0, 1, 1, 0, 0, 6'd0, 2'd0, '0);
      step(0, 1, 1, 1, 1, 0, 6'd0, 2'd0, '0);
      step(0, 0, 1, 1, 1, 0, 6'd0, 2'd0, '0);

      // Taken (000111, flags 00) and not-taken (000001, flags 01)
      cond_branch(6'd7, 2'b00, 32'h100);
      cond_branch(6'd1, 2'b01, 32'h200);
      step(0, 0, 0, 0, 0, 0, 6'd0, 2'd0, '0);

      // Taken branch meeting a 3-cycle stall
      step(0, 0, 1, 0, 0, 0, 6'd0, 2'd0, '0);
      step(0, 1, 0, 0, 0, 1, 6'd7, 2'b00, 32'h40);
      step(0, 1, 0, 0, 0, 0, 6'd0, 2'd0, '0);
      step(0, 1, 0, 0, 0, 0, 6'd0, 2'd0, '0);
      #1 chk("held_ta_0x40", 64'(held_ta), 64'h40);
      step(0, 0, 0, 0, 0, 0, 6'd0, 2'd0, '0);
      step(0, 0, 0, 0, 0, 0, 6'd0, 2'd0, '0);

      // Branch in the delay slot: sticky error
      step(0, 0, 1, 0, 0, 0, 6'd0, 2'd0, '0);
      step(0, 0, 1, 0, 0, 1, 6'd1, 2'b01, 32'h300);
      step(0, 0, 0, 0, 0, 0, 6'd0, 2'd0, '0);
      cond_branch(6'd7, 2'b00, 32'h400);
      #1 chk("ds_err_sticky", 64'(ds_err), 64'd1);

      // Reset while a redirect is pending
      step(0, 0, 1, 0, 0, 0, 6'd0, 2'd0, '0);
      step(0, 1, 0, 0, 0, 1, 6'd1, 2'b00, 32'h80);
      step(0, 1, 0, 0, 0, 0, 6'd0, 2'd0, '0);
      step(1, 1, 0, 0, 0, 0, 6'd0, 2'd0, '0);
      step(0, 0, 0, 0, 0, 0, 6'd0, 2'd0, '0);

      // Five branches, three taken
      cond_branch(6'd7, 2'b00, 32'h10);
      cond_branch(6'd1, 2'b00, 32'h20);
      cond_branch(6'd35, 2'b11, 32'h30);
      cond_branch(6'd1, 2'b01, 32'h40);
      cond_branch(6'd7, 2'b10, 32'h50);
      #1;
`ifdef BRANCH_STATS_EN
      chk("stat_branches_5", 64'(stat_branches), 64'd5);
      chk("stat_taken_3",    64'(stat_taken),    64'd3);
`else
      chk("stat_branches_off", 64'(stat_branches), 64'd0);
      chk("stat_taken_off",    64'(stat_taken),    64'd0);
`endif

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [5:0] op;
         case ($urandom_range(0, 2))
            0:       op = 6'd1;
            1:       op = 6'd7;
            default: op = 6'($urandom);
         endcase
         step($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
              op, 2'($urandom), 32'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
